// File: rtl/accum_frame_ctrl_16bit.sv
// accum_frame_ctrl_16bit
//   Frame accumulator built around one carry-select adder. Operand beats
//   arrive on a valid/ready port and are added to (or subtracted from) a
//   16-bit accumulator. The beat flagged in_last closes the frame. The
//   accumulated sum, the sticky carry/borrow flag, the sticky signed-overflow
//   flag and the beat count are then held on a valid/ready result port until
//   the consumer takes them.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake
//   in_data, in_sub, in_last operand, subtract mode, end-of-frame marker
//   out_valid/out_ready      result handshake
//   out_sum, out_carry, out_ovf, out_count  frame result fields
//
// carry_select_adder_16bit
//   16-bit adder made of four 4-bit blocks. Each block ripples twice, once
//   for carry-in 0 and once for carry-in 1. The real block carry then selects
//   one of the two precomputed results.

module carry_select_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] sum_lo, sum_hi;
  logic [3:0]  cout_lo, cout_hi;

  // Precompute both carry-in versions of every 4-bit block.
  always_comb begin
    logic c_lo;
    logic c_hi;
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    sum_lo  = '0;
    sum_hi  = '0;
    cout_lo = '0;
    cout_hi = '0;
    c_lo    = 1'b0;
    c_hi    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c_lo = 1'b0;
      c_hi = 1'b1;
      for (int i = 0; i < 4; i++) begin
        sum_lo[4*k+i] = a[4*k+i] ^ b[4*k+i] ^ c_lo;
        sum_hi[4*k+i] = a[4*k+i] ^ b[4*k+i] ^ c_hi;
        c_lo = (a[4*k+i] & b[4*k+i]) | (c_lo & (a[4*k+i] ^ b[4*k+i]));
        c_hi = (a[4*k+i] & b[4*k+i]) | (c_hi & (a[4*k+i] ^ b[4*k+i]));
      end
      cout_lo[k] = c_lo;
      cout_hi[k] = c_hi;
    end
  end

  // The carry chain runs only through the block-level select muxes.
  always_comb begin
    logic carry;
    sum   = '0;
    carry = cin;
    for (int k = 0; k < 4; k++) begin
      sum[4*k +: 4] = carry ? sum_hi[4*k +: 4] : sum_lo[4*k +: 4];
      carry         = carry ? cout_hi[k] : cout_lo[k];
    end
    cout = carry;
  end
endmodule

module accum_frame_ctrl_16bit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        acc_q, acc_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        accept, beat_wrap, beat_ovf;

  assign in_ready = (state_q != HOLD) && !rst;
  assign accept   = in_valid && in_ready;

  // Subtraction is a + ~b + 1. A frame-start beat uses zero in place of
  // the stale accumulator.
  assign add_a   = (state_q == IDLE) ? 16'h0000 : acc_q;
  assign add_b   = in_sub ? ~in_data : in_data;
  assign add_cin = in_sub;

  carry_select_adder_16bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // For a subtraction, a missing carry-out means a borrow occurred.
  assign beat_wrap = in_sub ? ~add_cout : add_cout;
  assign beat_ovf  = (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = add_sum;
          carry_d = beat_wrap;
          ovf_d   = beat_ovf;
          count_d = CNT_W'(1);
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = add_sum;
          carry_d = carry_q | beat_wrap;
          ovf_d   = ovf_q | beat_ovf;
          count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;
  assign out_count = count_q;
endmodule

// File: tb/tb_accum_frame_ctrl_16bit.sv
// Testbench for accum_frame_ctrl_16bit. A reference model computes each
// frame's result with signed/unsigned integer arithmetic and queues it. A
// monitor pops an entry on every result handshake and compares it.
module tb_accum_frame_ctrl_16bit;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_data = '0;
  logic             in_sub = 1'b0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic             out_carry;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  logic rand_ready  = 1'b0;
  logic ready_force = 1'b1;
  logic rnd_ready   = 1'b0;
  assign out_ready = rand_ready ? rnd_ready : ready_force;

  accum_frame_ctrl_16bit #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 rnd_ready = 1'($urandom_range(0, 1));
  end

  typedef struct {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
    int          count;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state for the frame currently being assembled.
  logic [15:0] m_acc      = '0;
  logic        m_carry    = 1'b0;
  logic        m_ovf      = 1'b0;
  int          m_count    = 0;
  bit          m_in_frame = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_beat(input logic [15:0] d, input logic s, input logic l);
    int   sa, sd, r;
    exp_t e;
    if (!m_in_frame) begin
      m_acc = '0; m_carry = 1'b0; m_ovf = 1'b0; m_count = 0; m_in_frame = 1'b1;
    end
    sa = int'($signed(m_acc));
    sd = int'($signed(d));
    r  = s ? sa - sd : sa + sd;
    if (s) m_carry = m_carry | (d > m_acc);
    else   m_carry = m_carry | ((int'(m_acc) + int'(d)) > 65535);
    m_ovf = m_ovf | (r > 32767) | (r < -32768);
    m_acc = 16'(r);
    if (m_count < CNT_MAX) m_count++;
    if (l) begin
      e.sum = m_acc; e.carry = m_carry; e.ovf = m_ovf; e.count = m_count;
      exp_q.push_back(e);
      m_in_frame = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_sum",   32'(out_sum),   32'(e.sum));
        check("out_carry", 32'(out_carry), 32'(e.carry));
        check("out_ovf",   32'(out_ovf),   32'(e.ovf));
        check("out_count", 32'(out_count), 32'(e.count));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic [15:0] d, input logic s, input logic l);
    bit accepted = 1'b0;
    in_valid = 1'b1; in_data = d; in_sub = s; in_last = l;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      if (in_ready) begin
        model_beat(d, s, l);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_sub   = 1'($urandom_range(0, 1));
    in_last  = 1'($urandom_range(0, 1));
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    else if (l) begin
      @(negedge clk);
      check("result_latency", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_sub   = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 2000 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    exp_q.delete();
    m_in_frame = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    do_reset();

    // Plain add frame.
    send_beat(16'h0001, 1'b0, 1'b0);
    send_beat(16'h0002, 1'b0, 1'b0);
    send_beat(16'h0003, 1'b0, 1'b1);
    wait_drain();

    // Signed overflow, then flags overwritten by the next frame.
    send_beat(16'h7FFF, 1'b0, 1'b0);
    send_beat(16'h0001, 1'b0, 1'b1);
    send_beat(16'h0004, 1'b0, 1'b1);
    wait_drain();

    // Unsigned carry.
    send_beat(16'hFFFF, 1'b0, 1'b0);
    send_beat(16'h0002, 1'b0, 1'b1);
    wait_drain();

    // Borrow on subtract.
    send_beat(16'h0005, 1'b0, 1'b0);
    send_beat(16'h0007, 1'b1, 1'b1);
    wait_drain();

    // Backpressure: result held while in_valid pulses are ignored.
    ready_force = 1'b0;
    send_beat(16'h0009, 1'b0, 1'b1);
    e = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom);
      in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_sum",   32'(out_sum),   32'(e.sum));
      check("bp_out_count", 32'(out_count), 32'(e.count));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    ready_force = 1'b1;
    @(posedge clk);
    #1 ready_force = 1'b0;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready),  32'd1);
    @(posedge clk);
    #1 ready_force = 1'b1;

    // Reset mid-frame abandons the partial frame.
    send_beat(16'h1234, 1'b0, 1'b0);
    send_beat(16'h1234, 1'b0, 1'b0);
    do_reset();
    send_beat(16'h0010, 1'b0, 1'b1);
    wait_drain();

    // Reset while holding a result drops it.
    ready_force = 1'b0;
    send_beat(16'h0001, 1'b0, 1'b1);
    do_reset();
    ready_force = 1'b1;

    // Long frame saturates the beat counter.
    for (int i = 0; i < CNT_MAX + 45; i++)
      send_beat(16'($urandom), 1'($urandom_range(0, 1)), (i == CNT_MAX + 44));
    wait_drain();

    // Random frames with random gaps and random consumer backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        idle_cycles($urandom_range(0, 2));
        send_beat(16'($urandom), 1'($urandom_range(0, 1)), (b == len - 1));
      end
    end
    wait_drain();
    rand_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
